morse_decoder: RTL and testbench
================================

# morse_decoder

Receive-side Morse block: consumes the serial dot/dash bit stream and per-bit strobe produced by the team's Morse letter transmitter and recovers the 3-bit letter code (A–H). It captures 12 bits, matches them against the shared 8-letter pattern table, and reports a decoded letter or an error. It sits at the far end of the transmitter's DotDashOut/NewBitOut pair, in the same ClockIn domain.

## Interface
- CLOCK_FREQUENCY, 500, ClockIn cycles per second. The transmitter bit period is CLOCK_FREQUENCY/2 cycles. Timeout limit is CLOCK_FREQUENCY cycles (two bit periods).
- ClockIn  input  1  sole clock; all state updates on its rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- DotDashIn  input  1  serial Morse bit: 1 = tone, 0 = gap.
- NewBitIn  input  1  bit strobe from the transmitter.
- Letter  output  3  last successfully decoded letter code (000=A … 111=H); reset 3'b000.
- LetterValid  output  1  one-cycle pulse; Letter updated this cycle; reset 0.
- Error  output  1  one-cycle pulse on mismatch or timeout; reset 0.
- Busy  output  1  high whenever FSM is not IDLE; reset 0.

## Operation
- Bit acceptance: a bit is accepted on a ClockIn edge where NewBitIn=1 and NewBitIn was 0 on the previous edge (rising-edge detect). A strobe held high for several cycles counts once. DotDashIn is sampled on that same edge.
- IDLE:
  - Accepted 0 bits are ignored, so the transmitter's trailing zeros are harmless.
  - An accepted 1 loads shift register {11'b0,1} and sets bit count to 1. The FSM goes to CAPTURE.
  - All pattern codes begin with 1.
- CAPTURE:
  - Each accepted bit shifts in at the LSB (MSB = first bit received). The count increments.
  - On the edge accepting bit 12, the FSM goes to MATCH.
- MATCH (exactly one cycle):
  - Compare the 12-bit word against the table: A 101110000000, B 111010101000, C 111010111010, D 111010100000, E 100000000000, F 101011101000, G 111011101000, H 101010100000.
  - On a hit: load Letter and pulse LetterValid.
  - On a miss: pulse Error; Letter is unchanged.
  - Then go to IDLE. Bits accepted during MATCH are dropped.
- Timeout:
  - In CAPTURE, a cycle counter of width $clog2(CLOCK_FREQUENCY+1) clears on every accepted bit and increments otherwise.
  - On reaching CLOCK_FREQUENCY, pulse Error, discard the partial word, and go to IDLE.
  - If a bit acceptance and the timeout occur on the same edge, the bit wins: the counter clears and no error is raised.
- Resetn low at any time: FSM to IDLE, shift register, count and timer to 0, all outputs to their reset values, edge-detect history to 0.

## Timing
- Latency: if edge k accepts bit 12, LetterValid or Error is high from edge k+1 to edge k+2. Busy falls at edge k+1.
- Busy rises on the edge that accepts the first 1.
- LetterValid and Error are never high together. Each is exactly 1 cycle wide.
- Letter is stable between LetterValid pulses.
- Back-to-back letters: a 1 accepted on edge k+2 or later starts a new capture. The minimum legal strobe spacing of 2 cycles is always met by the transmitter.
- Timeout Error is high for the one cycle after the edge on which the timer reaches CLOCK_FREQUENCY.

## Configuration
- MORSE_DEC_TIMEOUT_EN defined: the timeout counter and the timeout Error path are compiled in, as described above.
- Undefined: no timer is built. CAPTURE waits indefinitely for 12 bits. Error is raised only by a MATCH miss.

## Structure
- Shared package morse_pkg:
  - letter_t (3-bit code typedef).
  - The 8×12-bit pattern table constant, indexed by letter_t and also used by the transmitter.
  - MORSE_LEN = 12.
  - Decoder state enum {IDLE, CAPTURE, MATCH}.
- One sub-module, morse_bit_timer: the timeout counter with clear/enable/expired. It is instantiated only under MORSE_DEC_TIMEOUT_EN.

## Test plan
- Drive the transmitter pattern for C (111010111010), one strobe every 250 cycles -> LetterValid single pulse 1 cycle after bit 12, Letter=3'b010, Error=0.
- Send E (100000000000) immediately followed by A (101110000000) -> two LetterValid pulses, Letter=3'b100 then 3'b000. Trailing zeros between letters are ignored.
- Send non-table word 110000000000 -> Error pulse 1 cycle after bit 12, LetterValid=0, Letter keeps its prior value.
- With MORSE_DEC_TIMEOUT_EN: send 5 bits, then stop strobing -> Error exactly CLOCK_FREQUENCY cycles after the 5th bit, Busy=0. Without the macro: Busy stays 1 and no Error.
- Hold NewBitIn high 10 cycles per bit while sending H -> each bit counted once, Letter=3'b111.
- Assert Resetn=0 mid-capture after 7 bits, release, then send B -> no Error, no LetterValid during reset, then Letter=3'b001.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: letter codes, the 8-letter pattern table,
// word length and the decoder state encoding.
package morse_pkg;

  typedef logic [2:0] letter_t;

  localparam int MORSE_LEN = 12;

  // Index is the letter code: 0=A .. 7=H. MSB is the first bit on air.
  localparam logic [MORSE_LEN-1:0] MORSE_TABLE [8] = '{
    12'b101110000000,
    12'b111010101000,
    12'b111010111010,
    12'b111010100000,
    12'b100000000000,
    12'b101011101000,
    12'b111011101000,
    12'b101010100000
  };

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    MATCH
  } dec_state_t;

endpackage

// File: rtl/morse_bit_timer.sv
// Inter-bit timeout counter for the Morse decoder.
// Ports: clk, rst_n, clr_i (clear, wins), en_i (count), expired_o (reaches LIMIT this edge).
module morse_bit_timer #(
  parameter int unsigned LIMIT = 500,
  localparam int W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // Flags the edge on which the count steps onto LIMIT.
  assign expired_o = en_i && !clr_i &&
                     (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: captures 12 strobed bits, matches the letter table.
// Ports: ClockIn, Resetn (async low), DotDashIn, NewBitIn in;
// Letter[2:0], LetterValid, Error, Busy out. Timeout via MORSE_DEC_TIMEOUT_EN.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 500
) (
  input  logic       ClockIn,
  input  logic       Resetn,
  input  logic       DotDashIn,
  input  logic       NewBitIn,
  output logic [2:0] Letter,
  output logic       LetterValid,
  output logic       Error,
  output logic       Busy
);

  localparam int CNT_W = $clog2(MORSE_LEN + 1);

  dec_state_t           state_q, state_d;
  logic [MORSE_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  letter_t              letter_q, letter_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 nb_q;

  logic    accept;
  logic    timeout;
  logic    hit;
  letter_t hit_code;

  // Only the rising edge of the strobe carries a bit.
  assign accept = NewBitIn && !nb_q;

`ifdef MORSE_DEC_TIMEOUT_EN
  logic tmr_exp;

  morse_bit_timer #(
    .LIMIT(CLOCK_FREQUENCY)
  ) u_timer (
    .clk      (ClockIn),
    .rst_n    (Resetn),
    .clr_i    (accept || (state_q != CAPTURE)),
    .en_i     (state_q == CAPTURE),
    .expired_o(tmr_exp)
  );

  assign timeout = tmr_exp;
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    hit      = 1'b0;
    hit_code = '0;
    for (int i = 0; i < 8; i++) begin
      if (shift_q == MORSE_TABLE[letter_t'(i)]) begin
        hit      = 1'b1;
        hit_code = letter_t'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    letter_d = letter_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Leading zeros (transmitter tail) never start a word.
        if (accept && DotDashIn) begin
          shift_d = MORSE_LEN'(1);
          cnt_d   = CNT_W'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (accept) begin
          shift_d = {shift_q[MORSE_LEN-2:0], DotDashIn};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MORSE_LEN - 1))
            state_d = MATCH;
        end else if (timeout) begin
          err_d   = 1'b1;
          shift_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      MATCH: begin
        if (hit) begin
          letter_d = hit_code;
          valid_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
        shift_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        shift_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ClockIn or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      nb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      letter_q <= letter_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      nb_q     <= NewBitIn;
    end
  end

  assign Letter      = letter_q;
  assign LetterValid = valid_q;
  assign Error       = err_q;
  assign Busy        = (state_q != IDLE);

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed letters, timeout, reset,
// and random words checked against a queue-based word model.
module tb_morse_decoder;

  localparam int N = 500;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dd = 1'b0;
  logic       nb = 1'b0;
  logic [2:0] letter;
  logic       lv;
  logic       er;
  logic       busy;

  always #5 clk = ~clk;

  morse_decoder #(
    .CLOCK_FREQUENCY(N)
  ) dut (
    .ClockIn    (clk),
    .Resetn     (rst_n),
    .DotDashIn  (dd),
    .NewBitIn   (nb),
    .Letter     (letter),
    .LetterValid(lv),
    .Error      (er),
    .Busy       (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [11:0] ref_tab [8] = '{
    12'b101110000000, 12'b111010101000,
    12'b111010111010, 12'b111010100000,
    12'b100000000000, 12'b101011101000,
    12'b111011101000, 12'b101010100000
  };

  bit         mdl_bits[$];
  logic [2:0] exp_letter = 3'd0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One strobe: high for hold cycles, low for gap cycles.
  task automatic send_bit(input logic b,
                          input int hold,
                          input int gap);
    bit          done = 0;
    bit          hit = 0;
    bit          quiet = 1;
    logic [2:0]  code = 3'd0;
    logic [11:0] w;
    for (int i = 0; i < hold + gap; i++) begin
      @(negedge clk);
      nb = (i < hold);
      dd = b;
      @(posedge clk);
      #1;
      if (i == 0) begin
        if (mdl_bits.size() > 0 || b)
          mdl_bits.push_back(b);
        if (mdl_bits.size() == 12) begin
          w = '0;
          foreach (mdl_bits[j]) w = {w[10:0], mdl_bits[j]};
          mdl_bits.delete();
          done = 1;
          for (int l = 0; l < 8; l++)
            if (ref_tab[l] == w) begin
              hit = 1;
              code = 3'(l);
            end
          chk("busy_match", busy, 1);
        end else begin
          chk("busy_acc", busy, mdl_bits.size() > 0);
        end
      end else if (done && i == 1) begin
        chk("valid", lv, hit);
        chk("error", er, !hit);
        if (hit) exp_letter = code;
        chk("letter", letter, exp_letter);
        chk("busy_idle", busy, 0);
      end else if (done && i == 2) begin
        chk("valid_width", lv, 0);
        chk("error_width", er, 0);
      end else begin
        if (lv || er || letter !== exp_letter)
          quiet = 0;
      end
    end
    chk("quiet", quiet, 1);
  endtask

  task automatic send_word(input logic [11:0] w,
                           input int hold,
                           input int gap);
    for (int j = 11; j >= 0; j--)
      send_bit(w[j], hold, gap);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    nb = 1'b0;
    dd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", lv, 0);
    chk("rst_error", er, 0);
    chk("rst_busy", busy, 0);
    chk("rst_letter", letter, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mdl_bits.delete();
    exp_letter = 3'd0;
  endtask

  initial begin
    logic [11:0] w;
    int first_err;
    int n_err;
    logic busy_pre;
    logic busy_at;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_letter", letter, 0);
    chk("reset_valid", lv, 0);
    chk("reset_error", er, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // C at the transmitter's real bit rate
    send_word(12'b111010111010, 1, 249);
    chk("letter_C", letter, 3'b010);

    // E straight into A with trailing zeros in between
    send_word(12'b100000000000, 1, 3);
    send_bit(1'b0, 1, 3);
    send_bit(1'b0, 2, 2);
    send_word(12'b101110000000, 1, 3);
    chk("letter_A", letter, 3'b000);

    // Word not in the table
    send_word(12'b110000000000, 1, 3);
    chk("letter_kept", letter, 3'b000);

    // H with a long strobe
    send_word(12'b101010100000, 10, 5);
    chk("letter_H", letter, 3'b111);

    // Five bits then silence
    w = 12'b101110000000;
    for (int j = 11; j > 7; j--)
      send_bit(w[j], 1, 3);
    @(negedge clk);
    nb = 1'b1;
    dd = w[7];
    @(posedge clk);
    #1;
    chk("busy_5", busy, 1);
    first_err = 0;
    n_err = 0;
    busy_pre = 1'b0;
    busy_at = 1'b0;
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      nb = 1'b0;
      @(posedge clk);
      #1;
      if (er) begin
        n_err++;
        if (first_err == 0) first_err = c;
      end
      if (c == N - 1) busy_pre = busy;
      if (c == N) busy_at = busy;
    end
`ifdef MORSE_DEC_TIMEOUT_EN
    chk("tmo_first", first_err, N);
    chk("tmo_count", n_err, 1);
    chk("tmo_busy_pre", busy_pre, 1);
    chk("tmo_busy_at", busy_at, 0);
`else
    chk("notmo_count", n_err, 0);
    chk("notmo_busy_pre", busy_pre, 1);
    chk("notmo_busy_at", busy_at, 1);
`endif
    mdl_bits.delete();
    do_reset();

    // Reset in the middle of B, then a clean B
    w = 12'b111010101000;
    for (int j = 11; j > 4; j--)
      send_bit(w[j], 1, 3);
    do_reset();
    send_word(12'b111010101000, 1, 3);
    chk("letter_B", letter, 3'b001);

    // Random letters, noise words and zero padding
    for (int k = 0; k < 24; k++) begin
      if ($urandom_range(0, 3) == 0)
        w = {1'b1, 11'($urandom)};
      else
        w = ref_tab[$urandom_range(0, 7)];
      send_word(w, $urandom_range(1, 3),
                $urandom_range(2, 6));
      for (int z = 0; z < int'($urandom_range(0, 2)); z++)
        send_bit(1'b0, 1, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
